// File: rtl/sail_mem_pkg.sv
// Shared definitions for the data memory load/store initiator.
//   funct3 codes      : RV32I load/store size encodings
//   SM_* constants    : sign_mask fields seen by data_mem ([3] signed, [2:0] byte enables)
//   state_t           : master FSM states
//   LED_ADDR          : memory-mapped LED word; an ordinary word store as far as the master is concerned
package sail_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] SM_BYTE   = 4'b0001;
    localparam logic [3:0] SM_HALF   = 4'b0011;
    localparam logic [3:0] SM_WORD   = 4'b0111;
    localparam logic [3:0] SM_SIGNED = 4'b1000;

    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_size_decode.sv
// Combinational access decode: funct3 + low address bits -> data_mem sign_mask
// and a misaligned/illegal flag.
//   we        in  1  1 = store (stores are never signed; BU/HU are not store encodings)
//   funct3    in  3  RV32I funct3
//   addr_lo   in  2  byte address bits [1:0]
//   sign_mask out 4  [3] signed, [2:0] size
//   misaligned out 1 access must not reach memory
module mem_size_decode
    import sail_mem_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic [3:0] sign_mask,
    output logic       misaligned
);

    always_comb begin
        sign_mask  = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B: begin
                sign_mask = we ? SM_BYTE : (SM_BYTE | SM_SIGNED);
            end
            F3_H: begin
                sign_mask  = we ? SM_HALF : (SM_HALF | SM_SIGNED);
                misaligned = addr_lo[0];
            end
            F3_W: begin
                sign_mask  = SM_WORD;
                misaligned = (addr_lo != 2'b00);
            end
            F3_BU: begin
                sign_mask  = SM_BYTE;
                misaligned = we;
            end
            F3_HU: begin
                sign_mask  = SM_HALF;
                misaligned = we | addr_lo[0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_master.sv
// Load/store initiator between the core MEM stage and data_mem.
// Accepts one request, issues a single-cycle memread or memwrite, waits for the
// read completion (mem_clk_stall), and returns one response pulse.
//   clk, reset                      clock and async active-high reset
//   req_valid/req_ready             request handshake
//   req_we/req_funct3/req_addr/req_wdata  request payload
//   resp_valid/resp_rdata/resp_err  one-cycle response
//   mem_*                           data_mem interface
module data_mem_master
    import sail_mem_pkg::*;
#(
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]       dec_mask;
    logic             dec_misaligned;
    logic             accept;
    logic             capture;
    logic [31:0]      rdata_nx;
    logic             err_nx;

    mem_size_decode u_decode (
        .we         (req_we),
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .sign_mask  (dec_mask),
        .misaligned (dec_misaligned)
    );

    // data_mem has no reset; holding off while it still reports a read that was
    // in flight at reset keeps that stale completion from being taken as ours.
    assign req_ready = (state == ST_IDLE) & ~mem_clk_stall;
    assign accept    = req_valid & req_ready;
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rdata_nx = '0;
        err_nx   = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_misaligned) begin
                        err_nx   = 1'b1;
                        state_nx = ST_RESP;
                    end else begin
                        capture  = 1'b1;
                        state_nx = req_we ? ST_WR_ISSUE : ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                cnt_nx   = '0;
                state_nx = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_clk_stall) begin
                    rdata_nx = mem_read_data;
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        err_nx   = 1'b1;
                        state_nx = ST_RESP;
                    end
                end
            end
            ST_WR_ISSUE: begin
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Strobes and response are registered off the next state so each is a clean
    // one-cycle pulse aligned with the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            mem_memread  <= (state_nx == ST_RD_ISSUE);
            mem_memwrite <= (state_nx == ST_WR_ISSUE);
            resp_valid   <= (state_nx == ST_RESP);
            resp_rdata   <= rdata_nx;
            resp_err     <= err_nx;
        end
    end

    // Address/data/mask stay put after the access until the next accepted
    // aligned request; rejected requests never touch the memory bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
        end else if (capture) begin
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            mem_sign_mask  <= dec_mask;
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
module tb_data_mem_master;

    localparam int TIMEOUT   = 4;
    localparam int CNT_W     = 3;
    localparam int NO_ANSWER = 99;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr   = 32'h0;
    logic [31:0] req_wdata  = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_master #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    // data_mem stand-in: byte array, no reset, answers a read with a one-cycle
    // clk_stall pulse mdl_delay cycles after sampling memread.
    logic [7:0]  dmem [0:255] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:255];
    int          mdl_delay = 0;
    logic        rd_pend   = 1'b0;
    int          rd_left   = 0;
    logic [31:0] rd_addr   = 32'h0;
    logic [3:0]  rd_mask   = 4'h0;

    function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] v;
        v = {dmem[a[7:0] + 8'd3], dmem[a[7:0] + 8'd2], dmem[a[7:0] + 8'd1], dmem[a[7:0]]};
        case (m[2:0])
            3'b001:  v = m[3] ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
            3'b011:  v = m[3] ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        mem_clk_stall <= 1'b0;
        if (rd_pend) begin
            if (rd_left == 0) begin
                mem_clk_stall <= 1'b1;
                mem_read_data <= dm_read(rd_addr, rd_mask);
                rd_pend       <= 1'b0;
            end else begin
                rd_left <= rd_left - 1;
            end
        end else if (mem_memread) begin
            if (mdl_delay == 0) begin
                mem_clk_stall <= 1'b1;
                mem_read_data <= dm_read(mem_addr, mem_sign_mask);
            end else if (mdl_delay != NO_ANSWER) begin
                rd_pend <= 1'b1;
                rd_left <= mdl_delay - 1;
                rd_addr <= mem_addr;
                rd_mask <= mem_sign_mask;
            end
        end
        if (mem_memwrite) begin
            dmem[mem_addr[7:0]] <= mem_write_data[7:0];
            if (mem_sign_mask[1]) dmem[mem_addr[7:0] + 8'd1] <= mem_write_data[15:8];
            if (mem_sign_mask[2]) begin
                dmem[mem_addr[7:0] + 8'd2] <= mem_write_data[23:16];
                dmem[mem_addr[7:0] + 8'd3] <= mem_write_data[31:24];
            end
        end
    end

    int rd_pulses = 0;
    int wr_pulses = 0;

    always @(negedge clk) begin
        if (mem_memread)  rd_pulses++;
        if (mem_memwrite) wr_pulses++;
        if (!reset) begin
            checks++;
            assert (!(mem_memread && mem_memwrite)) else begin
                errors++;
                $error("FAIL rd_wr_exclusive: observed memread=%0b memwrite=%0b expected not both", mem_memread, mem_memwrite);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request end to end; expected results come from the access rules
    // applied to a byte-level shadow memory.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input string tag);
        int          size;
        logic        ok;
        logic        sgn;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_mask;
        int          exp_lat;
        int          lat;
        int          wait_cyc;

        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        ok = (size != 0) && !(we && f3[2]);
        if (ok) ok = (int'(addr[1:0]) % size) == 0;
        sgn       = !we && !f3[2] && (size < 4);
        exp_mask  = {sgn, size == 4, size >= 2, 1'b1};
        exp_err   = !ok || (!we && delay >= TIMEOUT);
        exp_lat   = !ok ? 1 : (we ? 2 : (delay < TIMEOUT ? 3 + delay : TIMEOUT + 2));
        exp_rdata = 32'h0;
        if (ok && !we && delay < TIMEOUT) begin
            for (int i = 0; i < size; i++)
                exp_rdata = exp_rdata | (32'(ref_mem[addr[7:0] + 8'(i)]) << (8 * i));
            if (sgn && size == 1 && exp_rdata[7])  exp_rdata = exp_rdata | 32'hFFFF_FF00;
            if (sgn && size == 2 && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
        end
        if (ok && we)
            for (int i = 0; i < size; i++)
                ref_mem[addr[7:0] + 8'(i)] = wdata[8*i +: 8];

        mdl_delay = delay;
        @(negedge clk);
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        rd_pulses  = 0;
        wr_pulses  = 0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_memread_cycles"}, 32'(rd_pulses), (ok && !we) ? 32'd1 : 32'd0);
        check({tag, "_memwrite_cycles"}, 32'(wr_pulses), (ok && we) ? 32'd1 : 32'd0);
        if (ok) begin
            check({tag, "_mem_addr"}, mem_addr, addr);
            check({tag, "_sign_mask"}, 32'(mem_sign_mask), 32'(exp_mask));
            if (we) check({tag, "_write_data"}, mem_write_data, wdata);
        end
        @(posedge clk);
        #1;
        check({tag, "_resp_one_cycle"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_memread", 32'(mem_memread), 32'd0);
        check("rst_memwrite", 32'(mem_memwrite), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_req(1'b1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 0, "sw_1004");
        do_req(1'b0, 3'b010, 32'h1004, 32'h0, 0, "lw_1004");
        do_req(1'b1, 3'b000, 32'h1001, 32'h0000_0080, 0, "sb_1001");
        do_req(1'b0, 3'b000, 32'h1001, 32'h0, 0, "lb_1001");
        do_req(1'b0, 3'b100, 32'h1001, 32'h0, 1, "lbu_1001");
        do_req(1'b1, 3'b001, 32'h1002, 32'h0000_8001, 0, "sh_1002");
        do_req(1'b0, 3'b001, 32'h1002, 32'h0, 2, "lh_1002");
        do_req(1'b0, 3'b101, 32'h1002, 32'h0, 0, "lhu_1002");
        do_req(1'b0, 3'b010, 32'h1002, 32'h0, 0, "lw_misaligned");
        do_req(1'b0, 3'b001, 32'h1003, 32'h0, 0, "lh_misaligned");
        do_req(1'b1, 3'b011, 32'h1008, 32'h1234_5678, 0, "bad_funct3");
        do_req(1'b1, 3'b010, 32'h2000, 32'h0000_00A5, 0, "sw_led");
        do_req(1'b0, 3'b010, 32'h1004, 32'h0, NO_ANSWER, "lw_timeout");
        do_req(1'b0, 3'b010, 32'h1004, 32'h0, TIMEOUT - 1, "lw_last_wait");

        // Reset in RD_WAIT while data_mem still owes a completion.
        mdl_delay = 2;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h1004;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrd_rst_memread", 32'(mem_memread), 32'd0);
        check("midrd_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrd_rst_mem_addr", mem_addr, 32'h0);
        check("midrd_rst_sign_mask", 32'(mem_sign_mask), 32'h0);
        check("midrd_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrd_stall_seen", 32'(mem_clk_stall), 32'd1);
        check("midrd_ready_held", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midrd_ready_back", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'b010, 32'h1004, 32'h0, 0, "lw_after_reset");

        for (int n = 0; n < 40; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            int          r_delay;
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_addr  = 32'h1000 + 32'($urandom_range(0, 31));
            r_delay = ($urandom_range(0, 7) == 0) ? NO_ANSWER : $urandom_range(0, TIMEOUT - 1);
            do_req(r_we, r_f3, r_addr, $urandom, r_delay, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
